btn_input: RTL and testbench
============================

BTN_INPUT -- requirements
Module: btn_input

Interface
REQ-001 Parameter DB_CYCLES, default 1_000_000: consecutive stable cycles required to accept a new button level.
REQ-002 Parameter RUN_DIV, default 67_108_864: cycles between cpu_ce pulses in run mode; legal range is 2 or more.
REQ-003 Port clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port btn_step, input, 1: raw, asynchronous single-step push button.
REQ-006 Port btn_run, input, 1: raw run/stop toggle push button.
REQ-007 Port btn_up, input, 1: raw button that increments the display address.
REQ-008 Port btn_down, input, 1: raw button that decrements the display address.
REQ-009 Port cpu_ce, output, 1: one-cycle CPU clock-enable pulse.
REQ-010 Port run_mode, output, 1: 1 = free-running, 0 = single-step.
REQ-011 Port disp_addr, output, 5: register-file address selected for display.
REQ-012 Port disp_en, output, 1: 1 while the address display is enabled; toggled by a simultaneous up+down press.

Function
REQ-013 Each raw button SHALL pass through a 2-flop synchronizer before debouncing.
REQ-014 The debounced level SHALL change only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any mismatch-free cycle SHALL clear the counter.
REQ-015 A debounced 0->1 transition SHALL produce exactly one press pulse, one cycle wide, in the cycle after the level updates; releases SHALL produce no pulse.
REQ-016 Total latency from a stable raw edge to the press pulse SHALL be DB_CYCLES+3 cycles.
REQ-017 A run press SHALL toggle run_mode and clear the run divider.
REQ-018 In run mode, the divider SHALL count 0..RUN_DIV-1 and wrap; cpu_ce SHALL be 1 exactly in cycles where the divider equals RUN_DIV-1.
REQ-019 In step mode, a step press SHALL drive cpu_ce high for exactly one cycle, in the same cycle as the press pulse.
REQ-020 Step presses in run mode SHALL be ignored.
REQ-021 In the cycle run_mode toggles, cpu_ce SHALL be 0.
REQ-022 An up press alone SHALL increment disp_addr modulo 32, so 31 wraps to 0.
REQ-023 A down press alone SHALL decrement disp_addr modulo 32, so 0 wraps to 31.
REQ-024 Up and down press pulses in the same cycle SHALL leave disp_addr unchanged and toggle disp_en.
REQ-025 cpu_ce SHALL never be high in two consecutive cycles.

Reset
REQ-026 While rst is high, all outputs SHALL be: cpu_ce=0, run_mode=0, disp_addr=0, disp_en=1.
REQ-027 While rst is high, all synchronizers, debounce counters and debounced levels SHALL be 0 and the divider SHALL be 0.
REQ-028 A button held through reset release SHALL be treated as a fresh press after DB_CYCLES+3 cycles.
REQ-029 Reset asserted mid-debounce or mid-divide SHALL abort the operation with no pulse emitted.

Structure
REQ-030 A shared package SHALL hold ADDR_W=5, the default DB_CYCLES and the default RUN_DIV.
REQ-031 The block SHALL contain one sub-module, debounce (synchronizer, counter, level, press pulse), instantiated four times; all remaining logic stays in btn_input.
REQ-032 All outputs SHALL be registered, with no combinational path from any input to any output.

Verification
REQ-033 Use DB_CYCLES=4, RUN_DIV=5; drive btn_step high for 10 cycles in step mode -> exactly one cpu_ce pulse, arriving 7 cycles after the edge.
REQ-034 Bounce btn_up 1-0-1-0 with 2-cycle glitches, then hold it high -> disp_addr increments exactly once.
REQ-035 Apply a down press at disp_addr=0 -> disp_addr becomes 31; apply an up press at 31 -> disp_addr becomes 0.
REQ-036 Apply a run press, then wait 20 cycles -> cpu_ce pulses every 5th cycle and step presses have no effect; a second run press stops the pulses.
REQ-037 Make up and down press pulses coincide -> disp_addr is unchanged and disp_en goes 1->0.
REQ-038 Assert rst mid-run, during a held button -> all outputs return to reset values immediately, with no cpu_ce glitch.

Source files
------------

// File: rtl/btn_input_pkg.sv
// ---------------------------------------------------------------------------
// btn_input_pkg
// Shared constants for the push-button front end: display address width,
// default debounce length and default free-run divider, plus a small helper
// that sizes a counter able to hold 0..n-1.
// ---------------------------------------------------------------------------
package btn_input_pkg;

    localparam int ADDR_W        = 5;
    localparam int DB_CYCLES_DEF = 1_000_000;
    localparam int RUN_DIV_DEF   = 67_108_864;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/btn_input_debounce.sv
// ---------------------------------------------------------------------------
// btn_input_debounce
// One raw push button: 2-flop synchronizer, stability counter, accepted
// level and a one-cycle press pulse on a debounced 0->1 transition.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   btn_i     : raw asynchronous button level
//   press_o   : registered press pulse, high the cycle after the level rises
//   press_d_o : next-state of press_o, lets the parent register its own
//               reaction in the very cycle press_o is high
// ---------------------------------------------------------------------------
module btn_input_debounce
    import btn_input_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o,
    output logic press_d_o
);

    localparam int               CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic             press_q;
    logic             press_d;

    // Count consecutive cycles of disagreement; accept the new level on the last one.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                level_d = sync2_q;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                level_d = level_q;
            end
        end else begin
            cnt_d   = '0;
            level_d = level_q;
        end
        // Rising edge of the accepted level, seen one cycle after it lands.
        press_d = level_q & ~level_prev_q;
    end

    // Synchronizer, stability counter, accepted level and press pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
        end
    end

    assign press_o   = press_q;
    assign press_d_o = press_d;

endmodule

// File: rtl/btn_input.sv
// ---------------------------------------------------------------------------
// btn_input
// Front-panel controller for a small CPU: debounces four raw buttons and
// turns their presses into a CPU clock enable (single step or free run) and
// a register-file display address with an enable toggle.
//
// Ports
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   btn_step   : raw single-step button
//   btn_run    : raw run/stop toggle button
//   btn_up     : raw display-address increment button
//   btn_down   : raw display-address decrement button
//   cpu_ce     : one-cycle CPU clock-enable pulse (registered)
//   run_mode   : 1 free-running, 0 single-step (registered)
//   disp_addr  : displayed register-file address (registered)
//   disp_en    : display enable, toggled by up+down together (registered)
// RUN_DIV must be 2 or more.
// ---------------------------------------------------------------------------
module btn_input
    import btn_input_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int RUN_DIV   = RUN_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_step,
    input  logic              btn_run,
    input  logic              btn_up,
    input  logic              btn_down,
    output logic              cpu_ce,
    output logic              run_mode,
    output logic [ADDR_W-1:0] disp_addr,
    output logic              disp_en
);

    localparam int               DIV_W    = cnt_width(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(RUN_DIV - 2);

    logic              step_press_s;
    logic              run_press_s;
    logic              up_press_s;
    logic              down_press_s;
    logic [3:0]        press_q_unused_s;

    logic              cpu_ce_q;
    logic              cpu_ce_d;
    logic              run_mode_q;
    logic              run_mode_d;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              en_q;
    logic              en_d;

    btn_input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_step),
        .press_o   (press_q_unused_s[0]),
        .press_d_o (step_press_s)
    );

    btn_input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_run),
        .press_o   (press_q_unused_s[1]),
        .press_d_o (run_press_s)
    );

    btn_input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_up),
        .press_o   (press_q_unused_s[2]),
        .press_d_o (up_press_s)
    );

    btn_input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_down),
        .press_o   (press_q_unused_s[3]),
        .press_d_o (down_press_s)
    );

    // Run/step control, divider and display address next-state.
    // Every register here is driven from the press next-state, so its new
    // value lands in the same cycle the debouncer's press pulse is high.
    always_comb begin
        run_mode_d = run_mode_q;
        div_d      = div_q;
        cpu_ce_d   = 1'b0;
        addr_d     = addr_q;
        en_d       = en_q;

        if (run_press_s) begin
            // Toggle cycle: restart the divider, never pulse.
            run_mode_d = ~run_mode_q;
            div_d      = '0;
            cpu_ce_d   = 1'b0;
        end else if (run_mode_q) begin
            // cpu_ce is set together with div reaching its last value.
            if (div_q == DIV_LAST) begin
                div_d    = '0;
                cpu_ce_d = 1'b0;
            end else begin
                div_d    = div_q + DIV_W'(1);
                cpu_ce_d = (div_q == DIV_PRE);
            end
        end else begin
            cpu_ce_d = step_press_s;
        end

        case ({up_press_s, down_press_s})
            2'b11:   en_d   = ~en_q;
            2'b10:   addr_d = addr_q + ADDR_W'(1);
            2'b01:   addr_d = addr_q - ADDR_W'(1);
            default: begin
                addr_d = addr_q;
                en_d   = en_q;
            end
        endcase
    end

    // Output and control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ce_q   <= 1'b0;
            run_mode_q <= 1'b0;
            div_q      <= '0;
            addr_q     <= '0;
            en_q       <= 1'b1;
        end else begin
            cpu_ce_q   <= cpu_ce_d;
            run_mode_q <= run_mode_d;
            div_q      <= div_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign run_mode  = run_mode_q;
    assign disp_addr = addr_q;
    assign disp_en   = en_q;

endmodule

// File: tb/tb_btn_input.sv
// ---------------------------------------------------------------------------
// tb_btn_input
// Self-checking bench for btn_input with DB_CYCLES=4, RUN_DIV=5. A reference
// model applies the button rules per cycle: a button's accepted level flips
// once the last DB_CYCLES synchronised samples all disagree with it, a press
// is a rise of that level seen one cycle later, and the top-level reaction
// (run toggle, step pulse, free-run pulse every RUN_DIV cycles, address
// up/down/toggle) follows from the presses.
// ---------------------------------------------------------------------------
module tb_btn_input;

    localparam int DB = 4;
    localparam int RD = 5;

    logic       clk;
    logic       rst;
    logic       btn_step;
    logic       btn_run;
    logic       btn_up;
    logic       btn_down;
    logic       cpu_ce;
    logic       run_mode;
    logic [4:0] disp_addr;
    logic       disp_en;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit       hist [4][$];
    bit       lvl  [4];
    bit       rose [4];
    bit       m_run;
    bit       m_en;
    bit       m_ce;
    bit [4:0] m_addr;
    int       m_phase;
    bit       prev_ce;
    int       ce_count;
    int       first;
    bit       got;
    bit [3:0] rnd;

    btn_input #(.DB_CYCLES(DB), .RUN_DIV(RD)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (btn_step),
        .btn_run   (btn_run),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .cpu_ce    (cpu_ce),
        .run_mode  (run_mode),
        .disp_addr (disp_addr),
        .disp_en   (disp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            hist[b].delete();
            for (int k = 0; k <= DB; k++) hist[b].push_back(1'b0);
            lvl[b]  = 1'b0;
            rose[b] = 1'b0;
        end
        m_run   = 1'b0;
        m_en    = 1'b1;
        m_ce    = 1'b0;
        m_addr  = 5'd0;
        m_phase = 0;
        prev_ce = 1'b0;
    endtask

    // One clock: sample raw buttons at the edge, advance the model, check at negedge.
    task automatic cycle();
        bit [3:0] raw;
        bit [3:0] prs;
        bit       all_diff;
        int       len;
        raw = {btn_down, btn_up, btn_run, btn_step};
        @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            prs[b]   = rose[b];
            len      = hist[b].size();
            all_diff = 1'b1;
            // samples reaching the counter: raw from 2..DB+1 edges back
            for (int k = 1; k <= DB; k++) begin
                if (hist[b][len-1-k] == lvl[b]) all_diff = 1'b0;
            end
            rose[b] = all_diff & ~lvl[b];
            if (all_diff) lvl[b] = ~lvl[b];
            hist[b].push_back(raw[b]);
            void'(hist[b].pop_front());
        end
        m_ce = 1'b0;
        if (prs[1]) begin
            m_run   = ~m_run;
            m_phase = 0;
        end else if (m_run) begin
            m_phase = m_phase + 1;
            m_ce    = ((m_phase % RD) == RD - 1);
        end else begin
            m_ce = prs[0];
        end
        if (prs[2] && prs[3]) m_en = ~m_en;
        else if (prs[2])      m_addr = m_addr + 5'd1;
        else if (prs[3])      m_addr = m_addr - 5'd1;
        @(negedge clk);
        check_eq("cpu_ce", cpu_ce, m_ce);
        check_eq("run_mode", run_mode, m_run);
        check_eq("disp_addr", disp_addr, m_addr);
        check_eq("disp_en", disp_en, m_en);
        check_eq("ce_back2back", cpu_ce & prev_ce, 1'b0);
        prev_ce  = cpu_ce;
        ce_count = ce_count + int'(cpu_ce);
    endtask

    task automatic drive(input bit [3:0] raw, input int n);
        {btn_down, btn_up, btn_run, btn_step} = raw;
        repeat (n) cycle();
    endtask

    task automatic press(input bit [3:0] raw);
        drive(raw, 8);
        drive(4'b0000, 8);
    endtask

    initial begin
        rst = 1'b1;
        {btn_down, btn_up, btn_run, btn_step} = 4'b0000;
        ce_count = 0;
        model_reset();
        #1;
        check_eq("rst_cpu_ce", cpu_ce, 1'b0);
        check_eq("rst_run_mode", run_mode, 1'b0);
        check_eq("rst_disp_addr", disp_addr, 5'd0);
        check_eq("rst_disp_en", disp_en, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(4'b0000, 4);

        // single step: 10-cycle press gives one pulse, 7 cycles after the edge
        ce_count = 0;
        first    = -1;
        btn_step = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (cpu_ce && first < 0) first = k;
        end
        drive(4'b0000, 10);
        check_eq("step_latency", first, 7);
        check_eq("step_pulses", ce_count, 1);

        // bouncing up button, then a solid hold: exactly one increment
        drive(4'b0100, 2);
        drive(4'b0000, 2);
        drive(4'b0100, 2);
        drive(4'b0000, 2);
        drive(4'b0100, 10);
        drive(4'b0000, 10);
        check_eq("bounce_addr", disp_addr, 5'd1);

        // wrap around in both directions
        press(4'b1000);
        check_eq("down_to_0", disp_addr, 5'd0);
        press(4'b1000);
        check_eq("down_wrap", disp_addr, 5'd31);
        press(4'b0100);
        check_eq("up_wrap", disp_addr, 5'd0);

        // up+down together: address held, display disabled
        press(4'b1100);
        check_eq("both_addr", disp_addr, 5'd0);
        check_eq("both_en", disp_en, 1'b0);

        // run mode: pulse every 5th cycle, step ignored, second press stops
        btn_run = 1'b1;
        got     = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            got = run_mode;
        end
        check_eq("run_on", run_mode, 1'b1);
        ce_count = 0;
        drive(4'b0001, 20);
        check_eq("run_pulses", ce_count, 4);
        drive(4'b0000, 10);
        btn_run = 1'b1;
        got     = 1'b1;
        for (int k = 0; k < 20 && got; k++) begin
            cycle();
            got = run_mode;
        end
        check_eq("run_off", run_mode, 1'b0);
        ce_count = 0;
        drive(4'b0000, 15);
        check_eq("stop_pulses", ce_count, 0);

        // reset mid-run while the up button is held mid-debounce
        btn_run = 1'b1;
        got     = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            got = run_mode;
        end
        check_eq("run_on2", run_mode, 1'b1);
        drive(4'b0100, 6);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_cpu_ce", cpu_ce, 1'b0);
        check_eq("mid_rst_run_mode", run_mode, 1'b0);
        check_eq("mid_rst_disp_addr", disp_addr, 5'd0);
        check_eq("mid_rst_disp_en", disp_en, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check_eq("in_rst_cpu_ce", cpu_ce, 1'b0);
            check_eq("in_rst_run_mode", run_mode, 1'b0);
        end
        rst = 1'b0;
        model_reset();
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (disp_addr == 5'd1 && first < 0) first = k;
        end
        check_eq("held_through_rst", first, 7);
        drive(4'b0000, 10);

        // randomized button activity against the model
        rnd = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) rnd[b] = ~rnd[b];
            end
            {btn_down, btn_up, btn_run, btn_step} = rnd;
            cycle();
        end
        drive(4'b0000, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
